// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared FSM state encoding and counter width for the button decoder
package btn_event_pkg;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_e;
endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registers the button level and flags its rising and falling edges
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic btn_q,
  output logic rise,
  output logic fall
);
  logic btn_d;
  // next level is simply the incoming sample
  always_comb btn_d = btn_level;
  // one-cycle delayed copy used as the edge reference
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) btn_q <= 1'b0;
    else btn_q <= btn_d;
  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;
endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a clean button level into press/release/short/long/double-click pulses
module btn_event_decoder
  import btn_event_pkg::*;
#(
  parameter int CLK_FREQ  = 125000000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic held
);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'((CLK_FREQ / 1000) * LONG_MS);
  localparam logic [CNT_W-1:0] DBL_CNT  = CNT_W'((CLK_FREQ / 1000) * DOUBLE_MS);

  if (LONG_CNT < 2 || DBL_CNT < 2) begin : g_bad_cfg
    $error("btn_event_decoder: LONG_CNT and DBL_CNT must both be >= 2");
  end

  logic btn_q, rise, fall;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;
  logic short_press_q, short_press_d;
  logic long_press_q, long_press_d;
  logic double_click_q, double_click_d;

  btn_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_level(btn_level),
    .btn_q    (btn_q),
    .rise     (rise),
    .fall     (fall)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // next state, counter and event pulses; edges take priority over timeouts
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;
    double_click_d  = 1'b0;
    case (state_q)
      IDLE:
        if (rise) begin
          state_d       = PRESSED;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
        end
      PRESSED:
        if (fall) begin
          state_d         = WAIT_SECOND;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end else if (cnt_q == LONG_CNT - CNT_W'(1)) begin
          state_d      = LONG_HELD;
          cnt_d        = '0;
          long_press_d = 1'b1;
        end else cnt_d = cnt_inc;
      LONG_HELD:
        if (fall) begin
          state_d         = IDLE;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end
      WAIT_SECOND:
        if (rise) begin
          state_d        = SECOND_PRESSED;
          cnt_d          = '0;
          press_pulse_d  = 1'b1;
          double_click_d = 1'b1;
        end else if (cnt_q == DBL_CNT - CNT_W'(1)) begin
          state_d       = IDLE;
          cnt_d         = '0;
          short_press_d = 1'b1;
        end else cnt_d = cnt_inc;
      SECOND_PRESSED:
        if (fall) begin
          state_d         = IDLE;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state, counter and registered event outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      double_click_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
      double_click_q  <= double_click_d;
    end

  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign short_press   = short_press_q;
  assign long_press    = long_press_q;
  assign double_click  = double_click_q;
  assign held          = btn_q;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: randomized and directed checks of the button decoder against an interval-based model
module tb_btn_event_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_level = 1'b0;
  logic press_pulse, release_pulse, short_press, long_press, double_click, held;
  int n_cmp = 0;
  int n_bad = 0;
  bit stim[$];
  logic [5:0] obs[$];
  logic [5:0] expv[$];

  always #5 clk = ~clk;

  btn_event_decoder #(.CLK_FREQ(1000), .LONG_MS(10), .DOUBLE_MS(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .held         (held)
  );

  // {press, release, short, long, double, held}
  function automatic logic [5:0] outs();
    return {press_pulse, release_pulse, short_press, long_press, double_click, held};
  endfunction

  task automatic do_reset();
    btn_level = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stim.delete();
  endtask

  task automatic add(input bit v, input int len);
    repeat (len) stim.push_back(v);
  endtask

  task automatic apply();
    obs.delete();
    foreach (stim[i]) begin
      btn_level = stim[i];
      @(posedge clk);
      #1 obs.push_back(outs());
    end
  endtask

  function automatic int next_edge(input int from, input bit lvl);
    for (int j = from; j < stim.size(); j++) begin
      bit prevb = (j == 0) ? 1'b0 : stim[j-1];
      if (stim[j] == lvl && prevb != lvl) return j;
    end
    return stim.size();
  endfunction

  // expected outputs from press/release intervals: hold of more than 10 samples is long,
  // a new press within 5 samples of release is a double click, otherwise short 5 after release
  function automatic void model();
    int n = stim.size();
    int p, r, q;
    expv.delete();
    for (int j = 0; j < n; j++) begin
      bit prevb = (j == 0) ? 1'b0 : stim[j-1];
      expv.push_back({stim[j] & ~prevb, ~stim[j] & prevb, 3'b000, stim[j]});
    end
    p = next_edge(0, 1'b1);
    while (p < n) begin
      r = next_edge(p + 1, 1'b0);
      if (r > p + 10) begin
        if (p + 10 < n) expv[p+10][2] = 1'b1;
        p = next_edge(r + 1, 1'b1);
      end else begin
        if (r >= n) break;
        q = next_edge(r + 1, 1'b1);
        if (q <= r + 5 && q < n) begin
          expv[q][1] = 1'b1;
          p = next_edge(next_edge(q + 1, 1'b0) + 1, 1'b1);
        end else begin
          if (r + 5 < n) expv[r+5][3] = 1'b1;
          p = q;
        end
      end
    end
  endfunction

  task automatic test_reset();
    btn_level = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_async got %b want %b", outs(), 6'b0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_held got %b want %b", outs(), 6'b0);
    end
  endtask

  task automatic test_single_click();
    do_reset();
    add(1'b1, 3);
    add(1'b0, 10);
    apply();
    model();
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL single[%0d] got %b want %b", i, obs[i], expv[i]);
      end
      n_cmp++;
      if ($countones(obs[i][3:1]) > 1 || (i > 0 && (obs[i][5:1] & obs[i-1][5:1]) != 5'b0)) begin
        n_bad++;
        $display("FAIL single_pulse[%0d] got %b prev %b want one-cycle exclusive pulses", i, obs[i], obs[i == 0 ? 0 : i-1]);
      end
    end
    n_cmp++;
    if (obs[8] !== 6'b001000) begin
      n_bad++;
      $display("FAIL single_short_at_8 got %b want %b", obs[8], 6'b001000);
    end
  endtask

  task automatic test_long_press();
    do_reset();
    add(1'b1, 20);
    add(1'b0, 10);
    apply();
    model();
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL long[%0d] got %b want %b", i, obs[i], expv[i]);
      end
      n_cmp++;
      if ($countones(obs[i][3:1]) > 1 || (i > 0 && (obs[i][5:1] & obs[i-1][5:1]) != 5'b0)) begin
        n_bad++;
        $display("FAIL long_pulse[%0d] got %b prev %b want one-cycle exclusive pulses", i, obs[i], obs[i == 0 ? 0 : i-1]);
      end
    end
    n_cmp++;
    if (obs[10] !== 6'b000101) begin
      n_bad++;
      $display("FAIL long_at_10 got %b want %b", obs[10], 6'b000101);
    end
  endtask

  task automatic test_double_click();
    do_reset();
    add(1'b1, 2);
    add(1'b0, 3);
    add(1'b1, 2);
    add(1'b0, 10);
    apply();
    model();
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL double[%0d] got %b want %b", i, obs[i], expv[i]);
      end
      n_cmp++;
      if ($countones(obs[i][3:1]) > 1 || (i > 0 && (obs[i][5:1] & obs[i-1][5:1]) != 5'b0)) begin
        n_bad++;
        $display("FAIL double_pulse[%0d] got %b prev %b want one-cycle exclusive pulses", i, obs[i], obs[i == 0 ? 0 : i-1]);
      end
    end
    n_cmp++;
    if (obs[5] !== 6'b100011) begin
      n_bad++;
      $display("FAIL double_at_5 got %b want %b", obs[5], 6'b100011);
    end
  endtask

  task automatic test_ties();
    do_reset();
    add(1'b1, 10);
    add(1'b0, 5);
    add(1'b1, 2);
    add(1'b0, 10);
    apply();
    model();
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== expv[i]) begin
        n_bad++;
        $display("FAIL ties[%0d] got %b want %b", i, obs[i], expv[i]);
      end
      n_cmp++;
      if ($countones(obs[i][3:1]) > 1 || (i > 0 && (obs[i][5:1] & obs[i-1][5:1]) != 5'b0)) begin
        n_bad++;
        $display("FAIL ties_pulse[%0d] got %b prev %b want one-cycle exclusive pulses", i, obs[i], obs[i == 0 ? 0 : i-1]);
      end
    end
    n_cmp++;
    if (obs[10] !== 6'b010000) begin
      n_bad++;
      $display("FAIL tie_fall_at_10 got %b want %b", obs[10], 6'b010000);
    end
    n_cmp++;
    if (obs[15] !== 6'b100011) begin
      n_bad++;
      $display("FAIL tie_rise_at_15 got %b want %b", obs[15], 6'b100011);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      do_reset();
      while (stim.size() < 50) begin
        add(1'b1, $urandom_range(1, 14));
        add(1'b0, $urandom_range(1, 8));
      end
      add(1'b0, 8);
      apply();
      model();
      for (int i = 0; i < obs.size(); i++) begin
        n_cmp++;
        if (obs[i] !== expv[i]) begin
          n_bad++;
          $display("FAIL random%0d[%0d] got %b want %b", k, i, obs[i], expv[i]);
        end
        n_cmp++;
        if ($countones(obs[i][3:1]) > 1 || (i > 0 && (obs[i][5:1] & obs[i-1][5:1]) != 5'b0)) begin
          n_bad++;
          $display("FAIL random%0d_pulse[%0d] got %b prev %b want one-cycle exclusive pulses", k, i, obs[i], obs[i == 0 ? 0 : i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_level = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_bad++;
      $display("FAIL midreset_async got %b want %b", outs(), 6'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (outs() !== 6'b0) begin
      n_bad++;
      $display("FAIL midreset_hold got %b want %b", outs(), 6'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== 6'b100001) begin
      n_bad++;
      $display("FAIL midreset_press got %b want %b", outs(), 6'b100001);
    end
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (outs() !== ((i == 10) ? 6'b000101 : 6'b000001)) begin
        n_bad++;
        $display("FAIL midreset_after[%0d] got %b want %b", i, outs(), (i == 10) ? 6'b000101 : 6'b000001);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_long_press();
    test_double_click();
    test_ties();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
